lsu_mem_if: RTL and testbench
=============================

// Module: lsu_mem_if
// PURPOSE
//  Load/store unit between the RV32I datapath (ALUResult = address, WriteData = store data)
//  and a word-wide data-memory bus with valid/ready request and rvalid response.
//  Builds byte strobes, aligns store data, sign/zero-extends load data into ReadData.
//  Drives stall so the core holds PC and register writes until the access completes.
// PARAMETERS
//  AW        32  byte-address width of addr and bus_addr
//  DW        32  data width; fixed at 32 for RV32I
// PORTS
//  clk         in   1   clock, rising edge
//  rst_n       in   1   asynchronous active-low reset
//  mem_req     in   1   memory instruction present this cycle (load or store)
//  mem_we      in   1   1 = store, 0 = load; valid with mem_req
//  funct3      in   3   000 B, 001 H, 010 W, 100 BU, 101 HU (loads); 000/001/010 stores
//  addr        in   AW  byte address (ALUResult)
//  wdata       in   DW  unaligned store data (WriteData, rs2)
//  ReadData    out  DW  extended load result, valid in DONE
//  stall       out  1   1 = core must hold PC and suppress RegWrite
//  misaligned  out  1   misaligned access flag (see CONFIGURATION)
//  bus_valid   out  1   request valid
//  bus_ready   in   1   request accepted when bus_valid & bus_ready
//  bus_we      out  1   request is a write
//  bus_addr    out  AW  word address {addr[AW-1:2],2'b00}
//  bus_wdata   out  DW  store data shifted to byte lane
//  bus_wstrb   out  4   byte enables (writes); 4'b1111 on reads
//  bus_rvalid  in   1   read response valid
//  bus_rdata   in   DW  read response word
// BEHAVIOUR
//  Reset: state=IDLE; bus_valid=0, bus_we=0, bus_addr=0, bus_wdata=0, bus_wstrb=0,
//   ReadData=0, misaligned=0. stall is combinational: mem_req & (state!=DONE).
//  FSM: IDLE --mem_req--> REQ: register we/funct3/addr/wdata, compute strobes+lane data.
//   REQ: bus_valid=1, outputs stable until bus_ready; accept -> store: DONE, load: RESP.
//   RESP: wait bus_rvalid; capture extended bus_rdata into ReadData -> DONE.
//   DONE: stall=0 one cycle, core advances -> IDLE unconditionally (no re-issue of same req).
//  Min latency with bus_ready=1, rvalid 1 cycle after accept: load 4 cycles, store 3.
//  Strobes: SB 4'b0001<<addr[1:0]; SH 4'b0011<<{addr[1],1'b0}; SW 4'b1111.
//  Store lanes: SB wdata[7:0] replicated x4; SH wdata[15:0] x2; SW wdata.
//  Load select: byte = rdata[8*addr[1:0]+:8], half = rdata[16*addr[1]+:16];
//   LB/LH sign-extend, LBU/LHU zero-extend, LW passes word. Undefined funct3 -> load as LW.
//  bus_rvalid outside RESP ignored. bus_ready outside REQ ignored.
//  mem_req deassert mid-access: access still completes (bus protocol not violated).
//  Async reset mid-access: immediately IDLE, bus_valid=0; any later response discarded.
// CONFIGURATION
//  LSU_MISALIGN_TRAP_EN defined: halfword with addr[0]=1 or word with addr[1:0]!=0 is
//   not issued; IDLE -> DONE directly, misaligned=1 during DONE, ReadData unchanged,
//   no bus traffic. Not defined: misaligned tied 0; low address bits ignored for
//   alignment (H uses addr[1], W uses word), access always issued.
// TESTING
//  SW addr=0x100 wdata=0xDEADBEEF, bus_ready=1 -> bus_wstrb=1111, bus_addr=0x100, stall 2 cycles.
//  SB addr=0x103 wdata=0x000000A5 -> bus_wstrb=1000, bus_wdata=0xA5A5A5A5, bus_addr=0x100.
//  LB addr=0x102, rdata=0x1280FF00 -> ReadData=0xFFFFFF80; LBU same -> 0x00000080.
//  LH addr=0x102, rdata=0x8001_1234 -> ReadData=0xFFFF8001; LHU -> 0x00008001.
//  LW with bus_ready low 3 cycles, rvalid 2 cycles later -> bus_valid/addr held stable,
//   stall high throughout, ReadData=rdata on DONE, 7 cycles total.
//  rst_n low during RESP, then rvalid pulse -> IDLE, bus_valid=0, ReadData=0, stall=mem_req;
//   with LSU_MISALIGN_TRAP_EN: LW addr=0x101 -> misaligned=1 in DONE, no bus_valid.

Source files
------------

// File: rtl/lsu_mem_if.sv
// rtl/lsu_mem_if.sv - RV32I load/store unit to a word-wide valid/ready data bus
// Optional feature: define LSU_MISALIGN_TRAP_EN to trap misaligned H/W accesses instead of issuing them.
module lsu_mem_if #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          mem_req,
    input  logic          mem_we,
    input  logic [2:0]    funct3,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] ReadData,
    output logic          stall,
    output logic          misaligned,
    output logic          bus_valid,
    input  logic          bus_ready,
    output logic          bus_we,
    output logic [AW-1:0] bus_addr,
    output logic [DW-1:0] bus_wdata,
    output logic [3:0]    bus_wstrb,
    input  logic          bus_rvalid,
    input  logic [DW-1:0] bus_rdata
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic          we_q;
    logic [2:0]    f3_q;
    logic [1:0]    off_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [3:0]    wstrb_q;
    logic [DW-1:0] rdata_q;
    logic          mis_q;

    logic          mis_det;
    logic [DW-1:0] lane_d;
    logic [3:0]    strb_d;
    logic [DW-1:0] ext_d;
    logic [7:0]    rbyte;
    logic [15:0]   rhalf;

    // funct3[1:0]: 00 byte, 01 half, anything else is treated as a word
`ifdef LSU_MISALIGN_TRAP_EN
    assign mis_det = (funct3[1:0] == 2'b01) ? addr[0]
                   : ((funct3[1:0] != 2'b00) && (addr[1:0] != 2'b00));
`else
    assign mis_det = 1'b0;
`endif

    always_comb begin
        lane_d = wdata;
        strb_d = 4'b1111;
        if (mem_we) begin
            case (funct3[1:0])
                2'b00: begin
                    lane_d = {4{wdata[7:0]}};
                    strb_d = 4'b0001 << addr[1:0];
                end
                2'b01: begin
                    lane_d = {2{wdata[15:0]}};
                    strb_d = addr[1] ? 4'b1100 : 4'b0011;
                end
                default: ;
            endcase
        end
    end

    assign rbyte = bus_rdata[{off_q, 3'b000} +: 8];
    assign rhalf = bus_rdata[{off_q[1], 4'b0000} +: 16];

    always_comb begin
        case (f3_q)
            3'b000:  ext_d = {{(DW-8){rbyte[7]}}, rbyte};
            3'b100:  ext_d = {{(DW-8){1'b0}}, rbyte};
            3'b001:  ext_d = {{(DW-16){rhalf[15]}}, rhalf};
            3'b101:  ext_d = {{(DW-16){1'b0}}, rhalf};
            default: ext_d = bus_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            off_q   <= 2'b00;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= 4'b0000;
            rdata_q <= '0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && mem_req) begin
                we_q    <= mem_we;
                f3_q    <= funct3;
                off_q   <= addr[1:0];
                addr_q  <= {addr[AW-1:2], 2'b00};
                wdata_q <= lane_d;
                wstrb_q <= strb_d;
                mis_q   <= mis_det;
            end
            if (state_q == S_RESP && bus_rvalid) begin
                rdata_q <= ext_d;
            end
            if (state_q == S_DONE) begin
                mis_q <= 1'b0;
            end
        end
    end

    // DONE always returns to IDLE so a held mem_req is never re-issued
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (mem_req) state_d = mis_det ? S_DONE : S_REQ;
            S_REQ:  if (bus_ready) state_d = we_q ? S_DONE : S_RESP;
            S_RESP: if (bus_rvalid) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus_valid  = (state_q == S_REQ);
        stall      = mem_req && (state_q != S_DONE);
        misaligned = mis_q;
        bus_we     = we_q;
        bus_addr   = addr_q;
        bus_wdata  = wdata_q;
        bus_wstrb  = wstrb_q;
        ReadData   = rdata_q;
    end
endmodule

// File: tb/tb_lsu_mem_if.sv
// tb/tb_lsu_mem_if.sv - scoreboard bench for lsu_mem_if
module tb_lsu_mem_if;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_req;
    logic        mem_we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] ReadData;
    logic        stall;
    logic        misaligned;
    logic        bus_valid;
    logic        bus_ready;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [3:0]  strb;
    } req_t;

    typedef struct packed {
        logic        chk_rd;
        logic [31:0] rd;
        logic        mis;
    } done_t;

    req_t  req_q[$];
    done_t done_q[$];

    lsu_mem_if #(.AW(32), .DW(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .funct3     (funct3),
        .addr       (addr),
        .wdata      (wdata),
        .ReadData   (ReadData),
        .stall      (stall),
        .misaligned (misaligned),
        .bus_valid  (bus_valid),
        .bus_ready  (bus_ready),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_wstrb  (bus_wstrb),
        .bus_rvalid (bus_rvalid),
        .bus_rdata  (bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    // Monitor: compares bus requests and completions against the queued expectations
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus_valid) begin
                if (req_q.size() == 0) begin
                    chk("unexpected_bus_valid", 32'(bus_valid), 32'd0);
                end else begin
                    chk("req_we", 32'(bus_we), 32'(req_q[0].we));
                    chk("req_addr", bus_addr, req_q[0].addr);
                    chk("req_strb", 32'(bus_wstrb), 32'(req_q[0].strb));
                    if (req_q[0].we) chk("req_wdata", bus_wdata, req_q[0].wd);
                    if (bus_ready) void'(req_q.pop_front());
                end
            end
            if (mem_req && !stall) begin
                if (done_q.size() == 0) begin
                    chk("unexpected_done", 32'(stall), 32'd1);
                end else begin
                    if (done_q[0].chk_rd) chk("done_readdata", ReadData, done_q[0].rd);
                    chk("done_misaligned", 32'(misaligned), 32'(done_q[0].mis));
                    void'(done_q.pop_front());
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 of the cycle after DONE with inputs idle
    task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rd, input int rdly,
                          input logic stray, input int exp_cyc, input logic [31:0] exp_rd,
                          input logic chk_rd, input logic exp_mis, input logic exp_bus,
                          input logic [31:0] exp_wd, input logic [3:0] exp_strb);
        int  n = 0;
        int  rc = 0;
        bit  acc = 0;
        bit  fin = 0;
        req_t  r;
        done_t d;
        r.we = we; r.addr = a & ~32'h3; r.wd = exp_wd; r.strb = exp_strb;
        d.chk_rd = chk_rd; d.rd = exp_rd; d.mis = exp_mis;
        if (exp_bus) req_q.push_back(r);
        done_q.push_back(d);
        mem_req = 1'b1; mem_we = we; funct3 = f3; addr = a; wdata = wd;
        while (!fin && n < 40) begin
            bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0;
            if (acc) begin
                if (!we) begin bus_rvalid = 1'b1; bus_rdata = rd; end
            end else begin
                if (stray) begin bus_rvalid = 1'b1; bus_rdata = 32'hBAD0BAD0; end
                if (bus_valid) begin
                    if (rc >= rdly) begin bus_ready = 1'b1; acc = 1; end
                    else rc++;
                end
            end
            n++;
            #1;
            if (!stall) fin = 1;
            @(posedge clk); #1;
        end
        if (!fin) chk("access_timeout", 32'(fin), 32'd1);
        chk("access_cycles", 32'(n), 32'(exp_cyc));
        mem_req = 1'b0; bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; mem_req = 1'b0; mem_we = 1'b0; funct3 = 3'b0; addr = 32'h0;
        wdata = 32'h0; bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0;
        #2;
        chk("rst_bus_valid", 32'(bus_valid), 32'd0);
        chk("rst_bus_we", 32'(bus_we), 32'd0);
        chk("rst_bus_addr", bus_addr, 32'h0);
        chk("rst_bus_wdata", bus_wdata, 32'h0);
        chk("rst_bus_wstrb", 32'(bus_wstrb), 32'h0);
        chk("rst_readdata", ReadData, 32'h0);
        chk("rst_misaligned", 32'(misaligned), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        access(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 0, 1'b0, 3, 32'h0, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 4'hF);
        access(1'b1, 3'b000, 32'h103, 32'h000000A5, 32'h0, 0, 1'b0, 3, 32'h0, 1'b0, 1'b0, 1'b1, 32'hA5A5A5A5, 4'h8);
        access(1'b1, 3'b001, 32'h102, 32'h1234BEEF, 32'h0, 1, 1'b0, 4, 32'h0, 1'b0, 1'b0, 1'b1, 32'hBEEFBEEF, 4'hC);
        access(1'b0, 3'b000, 32'h102, 32'h0, 32'h1280FF00, 0, 1'b0, 4, 32'hFFFFFF80, 1'b1, 1'b0, 1'b1, 32'h0, 4'hF);
        access(1'b0, 3'b100, 32'h102, 32'h0, 32'h1280FF00, 0, 1'b0, 4, 32'h00000080, 1'b1, 1'b0, 1'b1, 32'h0, 4'hF);
        access(1'b0, 3'b001, 32'h102, 32'h0, 32'h80011234, 0, 1'b0, 4, 32'hFFFF8001, 1'b1, 1'b0, 1'b1, 32'h0, 4'hF);
        access(1'b0, 3'b101, 32'h102, 32'h0, 32'h80011234, 0, 1'b0, 4, 32'h00008001, 1'b1, 1'b0, 1'b1, 32'h0, 4'hF);
        access(1'b0, 3'b010, 32'h104, 32'h0, 32'hCAFEF00D, 3, 1'b1, 7, 32'hCAFEF00D, 1'b1, 1'b0, 1'b1, 32'h0, 4'hF);
        access(1'b0, 3'b000, 32'h201, 32'h0, 32'h00007F00, 0, 1'b0, 4, 32'h0000007F, 1'b1, 1'b0, 1'b1, 32'h0, 4'hF);
        access(1'b0, 3'b001, 32'h200, 32'h0, 32'hFFFF7FFE, 0, 1'b0, 4, 32'h00007FFE, 1'b1, 1'b0, 1'b1, 32'h0, 4'hF);
        access(1'b0, 3'b011, 32'h300, 32'h0, 32'h89ABCDEF, 0, 1'b0, 4, 32'h89ABCDEF, 1'b1, 1'b0, 1'b1, 32'h0, 4'hF);

        bus_rvalid = 1'b1; bus_rdata = 32'h55555555;
        repeat (2) @(posedge clk);
        #1;
        bus_rvalid = 1'b0; bus_rdata = 32'h0;
        chk("idle_rvalid_ignored", ReadData, 32'h89ABCDEF);
        chk("idle_no_valid", 32'(bus_valid), 32'd0);

`ifdef LSU_MISALIGN_TRAP_EN
        access(1'b0, 3'b010, 32'h101, 32'h0, 32'h13572468, 0, 1'b0, 2, 32'h89ABCDEF, 1'b1, 1'b1, 1'b0, 32'h0, 4'hF);
`else
        access(1'b0, 3'b010, 32'h101, 32'h0, 32'h13572468, 0, 1'b0, 4, 32'h13572468, 1'b1, 1'b0, 1'b1, 32'h0, 4'hF);
`endif

        // Reset while waiting for the read response
        begin
            req_t r;
            r.we = 1'b0; r.addr = 32'h200; r.wd = 32'h0; r.strb = 4'hF;
            req_q.push_back(r);
        end
        mem_req = 1'b1; mem_we = 1'b0; funct3 = 3'b010; addr = 32'h200;
        @(posedge clk); #1;
        bus_ready = 1'b1;
        @(posedge clk); #1;
        bus_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_bus_valid", 32'(bus_valid), 32'd0);
        chk("rst_mid_readdata", ReadData, 32'h0);
        chk("rst_mid_stall", 32'(stall), 32'd1);
        mem_req = 1'b0;
        #1;
        chk("rst_mid_stall_noreq", 32'(stall), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus_rvalid = 1'b1; bus_rdata = 32'h11111111;
        @(posedge clk); #1;
        bus_rvalid = 1'b0; bus_rdata = 32'h0;
        @(posedge clk); #1;
        chk("post_rst_readdata", ReadData, 32'h0);
        chk("post_rst_bus_valid", 32'(bus_valid), 32'd0);

        repeat (3) @(posedge clk);
        chk("req_queue_empty", 32'(req_q.size()), 32'd0);
        chk("done_queue_empty", 32'(done_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
